sccb_reg_sequencer: RTL and testbench

Sequences OV7670 register accesses over the SCCB bus by driving the command and data AXI-stream ports of the i2c master. After reset it replays a boot table of register writes. The boot table comes from a ROM sub-module and may include timed delays. It then serves single read and write requests from the HCI/driver logic and returns a response for each. It sits between the camera driver's HCI and the i2c master, and is the only agent that issues SCCB traffic.

---
 rtl/sccb_pkg.sv | 25 ++
 rtl/sccb_init_rom.sv | 29 ++
 rtl/sccb_reg_sequencer.sv | 155 +++++++++++++++
 tb/tb_sccb_reg_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the OV7670 SCCB register sequencer.
package sccb_pkg;
    typedef enum logic [3:0] {
        INIT_FETCH,
        DELAY,
        IDLE,
        W_CMD,
        W_REG,
        W_VAL,
        R_CMD_A,
        R_REG,
        R_CMD_B,
        R_DATA,
        WAIT_IDLE,
        RESP
    } state_t;

    localparam logic [6:0] DEV_ADDR_OV7670 = 7'h21;
    localparam logic [7:0] DELAY_MARK = 8'hFF;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] val;
    } init_entry_t;
endpackage

// File: rtl/sccb_init_rom.sv
// sccb_init_rom: combinational OV7670 boot table; DELAY_MARK entries request a timed pause.
module sccb_init_rom
    import sccb_pkg::*;
(
    input  logic [7:0]  idx,
    output init_entry_t entry
);
    always_comb begin
        case (idx)
            8'd0:    entry = '{addr: 8'h12, val: 8'h80};
            8'd1:    entry = '{addr: DELAY_MARK, val: 8'h00};
            8'd2:    entry = '{addr: 8'h11, val: 8'h01};
            8'd3:    entry = '{addr: 8'h12, val: 8'h04};
            8'd4:    entry = '{addr: 8'h0C, val: 8'h00};
            8'd5:    entry = '{addr: 8'h3E, val: 8'h00};
            8'd6:    entry = '{addr: 8'h40, val: 8'hD0};
            8'd7:    entry = '{addr: 8'h3A, val: 8'h04};
            8'd8:    entry = '{addr: 8'h8C, val: 8'h00};
            8'd9:    entry = '{addr: 8'h17, val: 8'h13};
            8'd10:   entry = '{addr: 8'h18, val: 8'h01};
            8'd11:   entry = '{addr: 8'h32, val: 8'hB6};
            8'd12:   entry = '{addr: 8'h19, val: 8'h02};
            8'd13:   entry = '{addr: 8'h1A, val: 8'h7A};
            8'd14:   entry = '{addr: 8'h03, val: 8'h0A};
            8'd15:   entry = '{addr: 8'h15, val: 8'h00};
            default: entry = '{addr: 8'h11, val: 8'h01};
        endcase
    end
endmodule

// File: rtl/sccb_reg_sequencer.sv
// sccb_reg_sequencer: replays the OV7670 boot table, then serves single register
// read/write requests by driving the i2c master's command and data streams.
module sccb_reg_sequencer
    import sccb_pkg::*;
#(
    parameter int         INIT_LEN       = 64,
    parameter int         DELAY_CYCLES   = 100_000,
    parameter int         TIMEOUT_CYCLES = 65_536,
    parameter logic [6:0] DEV_ADDR       = DEV_ADDR_OV7670
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_read,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       init_done,
    output logic [6:0] s_axis_cmd_address,
    output logic       s_axis_cmd_start,
    output logic       s_axis_cmd_read,
    output logic       s_axis_cmd_write,
    output logic       s_axis_cmd_write_multiple,
    output logic       s_axis_cmd_stop,
    output logic       s_axis_cmd_valid,
    input  logic       s_axis_cmd_ready,
    output logic [7:0] s_axis_data_tdata,
    output logic       s_axis_data_tvalid,
    output logic       s_axis_data_tlast,
    input  logic       s_axis_data_tready,
    input  logic [7:0] m_axis_data_tdata,
    input  logic       m_axis_data_tvalid,
    input  logic       m_axis_data_tlast,
    output logic       m_axis_data_tready,
    input  logic       i2c_busy
);
    localparam int DW = DELAY_CYCLES > 1 ? $clog2(DELAY_CYCLES) : 1;

    state_t          state, state_nxt;
    init_entry_t     entry;
    logic [16:0]     tmo_cnt;
    logic [DW-1:0]   dly_cnt;
    logic [7:0]      idx, addr, val, rdata;
    logic            rd, phase, err, abort, req_fire, tmo_hit, last_entry, waiting;
    logic            unused_tlast;

    sccb_init_rom u_rom (.idx(idx), .entry(entry));

    assign unused_tlast       = m_axis_data_tlast;
    assign s_axis_cmd_address = DEV_ADDR;
    assign s_axis_cmd_write   = 1'b0;
    assign req_ready          = state == IDLE && init_done;
    assign req_fire           = req_valid && req_ready;
    assign rsp_valid          = state == RESP && init_done;
    assign rsp_err            = rsp_valid && err;
    assign rsp_data           = rsp_valid && !err ? rdata : 8'h00;
    assign tmo_hit            = tmo_cnt == 17'(TIMEOUT_CYCLES - 1);
    assign last_entry         = idx == 8'(INIT_LEN - 1);
    assign waiting            = state inside {W_CMD, W_REG, W_VAL, R_CMD_A, R_REG, R_CMD_B, R_DATA, WAIT_IDLE};

    always_comb begin
        state_nxt                 = state;
        abort                     = 1'b0;
        s_axis_cmd_valid          = 1'b0;
        s_axis_cmd_start          = 1'b0;
        s_axis_cmd_read           = 1'b0;
        s_axis_cmd_write_multiple = 1'b0;
        s_axis_cmd_stop           = 1'b0;
        s_axis_data_tvalid        = 1'b0;
        s_axis_data_tdata         = 8'h00;
        s_axis_data_tlast         = 1'b0;
        m_axis_data_tready        = 1'b0;
        case (state)
            INIT_FETCH: state_nxt = entry.addr == DELAY_MARK ? DELAY : W_CMD;
            DELAY:      state_nxt = dly_cnt == DW'(DELAY_CYCLES - 1) ? RESP : DELAY;
            IDLE:       state_nxt = !req_fire ? IDLE : req_read ? R_CMD_A : W_CMD;
            W_CMD, R_CMD_A, R_CMD_B: begin
                s_axis_cmd_valid          = 1'b1;
                s_axis_cmd_start          = 1'b1;
                s_axis_cmd_stop           = 1'b1;
                s_axis_cmd_read           = state == R_CMD_B;
                s_axis_cmd_write_multiple = state != R_CMD_B;
                state_nxt = !s_axis_cmd_ready ? state : state == W_CMD ? W_REG : state == R_CMD_A ? R_REG : R_DATA;
            end
            W_REG, W_VAL, R_REG: begin
                s_axis_data_tvalid = 1'b1;
                s_axis_data_tdata  = state == W_VAL ? val : addr;
                s_axis_data_tlast  = state != W_REG;
                state_nxt = !s_axis_data_tready ? state : state == W_REG ? W_VAL : WAIT_IDLE;
            end
            R_DATA: begin
                m_axis_data_tready = 1'b1;
                state_nxt = m_axis_data_tvalid ? WAIT_IDLE : R_DATA;
            end
            // first cycle ignores busy so the master has time to raise it
            WAIT_IDLE:  state_nxt = tmo_cnt != '0 && !i2c_busy ? (rd && !phase ? R_CMD_B : RESP) : WAIT_IDLE;
            RESP:       state_nxt = init_done || last_entry ? IDLE : INIT_FETCH;
            default:    state_nxt = INIT_FETCH;
        endcase
        if (waiting && state_nxt == state && tmo_hit) begin
            state_nxt = RESP;
            abort     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT_FETCH;
            tmo_cnt   <= '0;
            dly_cnt   <= '0;
            idx       <= '0;
            addr      <= '0;
            val       <= '0;
            rdata     <= '0;
            rd        <= 1'b0;
            phase     <= 1'b0;
            err       <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= state_nxt != state ? '0 : tmo_cnt + 17'd1;
            dly_cnt <= state == DELAY ? dly_cnt + DW'(1) : '0;
            if (state == INIT_FETCH) begin
                addr  <= entry.addr;
                val   <= entry.val;
                rd    <= 1'b0;
                phase <= 1'b0;
                err   <= 1'b0;
                rdata <= '0;
            end
            if (req_fire) begin
                addr  <= req_addr;
                val   <= req_data;
                rd    <= req_read;
                phase <= 1'b0;
                err   <= 1'b0;
                rdata <= '0;
            end
            if (state == R_CMD_B) phase <= 1'b1;
            if (state == R_DATA && m_axis_data_tvalid) rdata <= m_axis_data_tdata;
            if (abort) begin
                err   <= 1'b1;
                rdata <= '0;
            end
            // boot entries advance through RESP whether written, delayed or aborted
            if (state == RESP && !init_done) begin
                if (last_entry) init_done <= 1'b1;
                else idx <= idx + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_sccb_reg_sequencer.sv
// tb_sccb_reg_sequencer: directed bench with a small i2c master model driven from the stimulus thread.
module tb_sccb_reg_sequencer;
    localparam int INIT_LEN = 3, DLY = 20, TMO = 40;

    logic       clk = 1'b0, reset = 1'b1;
    logic       req_valid = 1'b0, req_ready, req_read = 1'b0;
    logic [7:0] req_addr = 8'h00, req_data = 8'h00;
    logic       rsp_valid, rsp_err, init_done;
    logic [7:0] rsp_data;
    logic [6:0] cmd_address;
    logic       cmd_start, cmd_read, cmd_write, cmd_wm, cmd_stop, cmd_valid, cmd_ready = 1'b1;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tlast, s_tready = 1'b1;
    logic [7:0] m_tdata = 8'h00;
    logic       m_tvalid = 1'b0, m_tlast = 1'b1, m_tready, i2c_busy = 1'b0;

    always #5 clk = ~clk;

    sccb_reg_sequencer #(.INIT_LEN(INIT_LEN), .DELAY_CYCLES(DLY), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .init_done(init_done),
        .s_axis_cmd_address(cmd_address), .s_axis_cmd_start(cmd_start), .s_axis_cmd_read(cmd_read),
        .s_axis_cmd_write(cmd_write), .s_axis_cmd_write_multiple(cmd_wm), .s_axis_cmd_stop(cmd_stop),
        .s_axis_cmd_valid(cmd_valid), .s_axis_cmd_ready(cmd_ready),
        .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid), .s_axis_data_tlast(s_tlast),
        .s_axis_data_tready(s_tready),
        .m_axis_data_tdata(m_tdata), .m_axis_data_tvalid(m_tvalid), .m_axis_data_tlast(m_tlast),
        .m_axis_data_tready(m_tready), .i2c_busy(i2c_busy)
    );

    int checks = 0, failures = 0, cyc = 0;
    logic [8:0] dlog[$];
    int         dcyc[$];
    logic [3:0] clog[$];
    int         ccyc[$];
    int         rsp_cnt = 0, rsp_bad = 0, stable_err = 0, addr_err = 0, cmdv_cycles = 0;
    logic [7:0] rsp_d = 8'h00, rd_val = 8'h00;
    logic       rsp_e = 1'b0, bp = 1'b0, bp_active = 1'b0, m_drop = 1'b0;
    logic [8:0] snap = 9'h000;
    int         bp_cnt = 0, hold = 0, rd_wait = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock step: sample at negedge, then update the i2c master model for the next edge
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (reset) begin
            i2c_busy = 1'b0; hold = 0; m_tvalid = 1'b0; m_drop = 1'b0; rd_wait = 0; bp_active = 1'b0;
        end else begin
            if (m_drop) begin
                m_tvalid = 1'b0; m_drop = 1'b0; hold = 3;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) i2c_busy = 1'b0;
            end
            if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0) begin m_tvalid = 1'b1; m_tdata = rd_val; end
            end
            if (m_tvalid && m_tready) m_drop = 1'b1;
            if (bp && s_tvalid) begin
                if (!bp_active) begin
                    bp_active = 1'b1; bp_cnt = 20; snap = {s_tlast, s_tdata};
                end else if ({s_tlast, s_tdata} !== snap) stable_err++;
                s_tready = bp_cnt == 0;
                if (bp_cnt > 0) bp_cnt--;
            end
            if (s_tvalid && s_tready) begin
                dlog.push_back({s_tlast, s_tdata}); dcyc.push_back(cyc);
                bp_active = 1'b0;
                if (s_tlast) hold = 3;
            end
            if (cmd_valid) cmdv_cycles++;
            if (cmd_valid && cmd_ready) begin
                clog.push_back({cmd_start, cmd_read, cmd_wm, cmd_stop}); ccyc.push_back(cyc);
                i2c_busy = 1'b1; hold = 0;
                if (cmd_read) rd_wait = 3;
                if (cmd_address !== 7'h21 || cmd_write !== 1'b0) addr_err++;
            end
            if (rsp_valid) begin
                rsp_cnt++; rsp_d = rsp_data; rsp_e = rsp_err;
                if (cmd_valid || s_tvalid) rsp_bad++;
            end
        end
    endtask

    task automatic send(input logic rd, input logic [7:0] a, input logic [7:0] d);
        int k = 0;
        req_read = rd; req_addr = a; req_data = d; req_valid = 1'b1;
        while (!req_ready && k < 50) begin tick(); k++; end
        tick();
        req_valid = 1'b0;
        check("accept_ready_drop", req_ready, 1'b0);
        check("accept_cmd_valid", cmd_valid, 1'b1);
    endtask

    task automatic wait_rsp(input int n0, input int bound);
        int k = 0;
        while (rsp_cnt == n0 && k < bound) begin tick(); k++; end
        check("rsp_arrived", rsp_cnt, n0 + 1);
        repeat (3) tick();
        check("rsp_once", rsp_cnt, n0 + 1);
    endtask

    task automatic clear_logs();
        dlog.delete(); dcyc.delete(); clog.delete(); ccyc.delete();
    endtask

    localparam logic [35:0] BOOT_EXP = {9'h012, 9'h180, 9'h011, 9'h101};

    initial begin
        int k, n0;
        repeat (3) tick();
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_data_tvalid", s_tvalid, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", {rsp_valid, rsp_err, rsp_data}, 10'h000);
        check("rst_init_done", init_done, 1'b0);
        check("rst_m_tready", m_tready, 1'b0);
        check("rst_cmd_address", cmd_address, 7'h21);
        reset = 1'b0;

        k = 0;
        while (!init_done && k < 400) begin tick(); k++; end
        check("boot_done", init_done, 1'b1);
        check("boot_bytes_n", dlog.size(), 4);
        check("boot_bytes", dlog.size() >= 4 ? {dlog[0], dlog[1], dlog[2], dlog[3]} : 36'h0, BOOT_EXP);
        check("boot_cmds_n", clog.size(), 2);
        check("boot_cmd0", clog.size() >= 1 ? clog[0] : 4'h0, 4'b1011);
        check("boot_delay_gap", (dcyc.size() >= 2 && ccyc.size() >= 2 &&
              ccyc[1] - dcyc[1] >= DLY && ccyc[1] - dcyc[1] <= DLY + 15), 1'b1);
        check("boot_no_rsp", rsp_cnt, 0);
        tick();
        check("idle_req_ready", req_ready, 1'b1);

        clear_logs(); n0 = rsp_cnt;
        send(1'b0, 8'h3A, 8'h04);
        wait_rsp(n0, 200);
        check("wr_bytes", dlog.size() == 2 ? {dlog[0], dlog[1]} : 18'h0, {9'h03A, 9'h104});
        check("wr_rsp", {rsp_e, rsp_d}, 9'h000);

        clear_logs(); n0 = rsp_cnt; rd_val = 8'h76;
        send(1'b1, 8'h0A, 8'h00);
        wait_rsp(n0, 200);
        check("rd_cmds", clog.size() == 2 ? {clog[0], clog[1]} : 8'h0, {4'b1011, 4'b1101});
        check("rd_bytes", dlog.size() == 1 ? dlog[0] : 9'h0, 9'h10A);
        check("rd_rsp", {rsp_e, rsp_d}, 9'h076);

        clear_logs(); n0 = rsp_cnt; bp = 1'b1; s_tready = 1'b0; stable_err = 0;
        send(1'b0, 8'h5C, 8'hA7);
        wait_rsp(n0, 300);
        check("bp_bytes", dlog.size() == 2 ? {dlog[0], dlog[1]} : 18'h0, {9'h05C, 9'h1A7});
        check("bp_stable", stable_err, 0);
        check("bp_rsp", {rsp_e, rsp_d}, 9'h000);
        bp = 1'b0; s_tready = 1'b1;

        clear_logs(); n0 = rsp_cnt; cmd_ready = 1'b0; cmdv_cycles = 0; rsp_bad = 0;
        send(1'b0, 8'h10, 8'h20);
        wait_rsp(n0, 200);
        check("tmo_rsp", {rsp_e, rsp_d}, 9'h100);
        check("tmo_valids_dropped", rsp_bad, 0);
        check("tmo_cmd_valid_low", cmd_valid, 1'b0);
        check("tmo_duration", cmdv_cycles >= TMO && cmdv_cycles <= TMO + 1, 1'b1);
        check("tmo_no_cmds", clog.size(), 0);
        cmd_ready = 1'b1;

        clear_logs(); n0 = rsp_cnt;
        send(1'b0, 8'h11, 8'h02);
        wait_rsp(n0, 200);
        check("post_tmo_bytes", dlog.size() == 2 ? {dlog[0], dlog[1]} : 18'h0, {9'h011, 9'h102});
        check("post_tmo_rsp", {rsp_e, rsp_d}, 9'h000);

        clear_logs(); bp = 1'b1; s_tready = 1'b0;
        send(1'b0, 8'h3B, 8'h0A);
        k = 0;
        while (!(s_tvalid && s_tlast) && k < 200) begin tick(); k++; end
        check("reached_w_val", {s_tvalid, s_tlast, s_tdata}, 10'h30A);
        reset = 1'b1;
        tick();
        check("mid_rst_valids", {cmd_valid, s_tvalid, m_tready, rsp_valid}, 4'h0);
        check("mid_rst_init_done", init_done, 1'b0);
        check("mid_rst_req_ready", req_ready, 1'b0);
        check("mid_rst_partial", dlog.size() == 1 ? dlog[0] : 9'h0, 9'h03B);
        bp = 1'b0; s_tready = 1'b1; clear_logs();
        tick();
        reset = 1'b0;
        k = 0;
        while (!init_done && k < 400) begin tick(); k++; end
        check("reboot_done", init_done, 1'b1);
        check("reboot_bytes", dlog.size() >= 4 ? {dlog[0], dlog[1], dlog[2], dlog[3]} : 36'h0, BOOT_EXP);
        check("cmd_address_all", addr_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
